// File: rtl/prog_frame_loader_pkg.sv
// rtl/prog_frame_loader_pkg.sv - shared sizes and FSM state type for the program frame loader
package gpu_loader_pkg;

  localparam int DEF_FRAME_W  = 16;
  localparam int DEF_N_FRAMES = 1024;
  localparam int DEF_CNT_W    = $clog2(DEF_N_FRAMES) + 1;
  localparam int CSUM_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    HOLD,
    DRAIN
  } state_t;

endpackage

// File: rtl/prog_frame_loader_if.sv
// rtl/prog_frame_loader_if.sv - host word stream into the program frame loader
interface prog_frame_loader_if
  import gpu_loader_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W
);

  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] in_data;
  logic               in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/prog_frame_store.sv
// rtl/prog_frame_store.sv - frame image register array with single write port and clear-all
module prog_frame_store
  import gpu_loader_pkg::*;
#(
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int N_FRAMES = DEF_N_FRAMES,
  localparam int AW      = $clog2(N_FRAMES)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              we,
  input  logic                              clr,
  input  logic [AW-1:0]                     widx,
  input  logic [FRAME_W-1:0]                wdata,
  output logic [N_FRAMES-1:0][FRAME_W-1:0]  frames
);

  // The write is issued after the clear so a first beat lands in the freshly cleared image.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frames <= '0;
    end else begin
      if (clr) frames <= '0;
      if (we)  frames[widx] <= wdata;
    end
  end

endmodule

// File: rtl/prog_frame_loader.sv
// rtl/prog_frame_loader.sv - assembles host words into a held frame image; LOADER_CHECKSUM_EN adds last-beat checksum
module prog_frame_loader
  import gpu_loader_pkg::*;
#(
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int N_FRAMES = DEF_N_FRAMES,
  localparam int CNT_W   = $clog2(N_FRAMES) + 1,
  localparam int AW      = $clog2(N_FRAMES)
) (
  input  logic                              clk,
  input  logic                              reset,
  prog_frame_loader_if.slave                host,
  input  logic                              prog_done,
  output logic                              prog_loading,
  output logic [N_FRAMES-1:0][FRAME_W-1:0]  data_frames_out,
  output logic [CNT_W-1:0]                  frame_count,
  output logic                              busy,
  output logic                              error
);

  state_t           state, state_n;
  logic [CNT_W-1:0] idx, idx_n, fc_n;
  logic             err_n, we, clr, beat, full;
  logic [AW-1:0]    wr_idx;
`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum, csum_n;
`endif

  assign host.in_ready = (state == IDLE) || (state == LOAD) || (state == DRAIN);
  assign beat          = host.in_valid && host.in_ready;
  assign full          = (idx == CNT_W'(N_FRAMES));
  assign busy          = (state != IDLE);
  assign wr_idx        = (state == IDLE) ? '0 : idx[AW-1:0];

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    fc_n         = frame_count;
    err_n        = error;
    we           = 1'b0;
    clr          = 1'b0;
    prog_loading = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_n       = csum;
`endif
    case (state)
      IDLE: if (beat) begin
        clr   = 1'b1;
        err_n = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_n = '0;
        idx_n  = '0;
        if (host.in_last) begin
          // Zero-length program: the lone beat is the checksum of nothing.
          if (CSUM_W'(host.in_data) == '0) begin
            fc_n    = '0;
            state_n = ARM;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          we      = 1'b1;
          idx_n   = CNT_W'(1);
          csum_n  = CSUM_W'(host.in_data);
          state_n = LOAD;
        end
`else
        we    = 1'b1;
        idx_n = CNT_W'(1);
        if (host.in_last) begin
          fc_n    = CNT_W'(1);
          state_n = ARM;
        end else begin
          state_n = LOAD;
        end
`endif
      end
      LOAD: if (beat) begin
`ifdef LOADER_CHECKSUM_EN
        if (host.in_last) begin
          if (csum == CSUM_W'(host.in_data)) begin
            fc_n    = idx;
            state_n = ARM;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (full) begin
          err_n   = 1'b1;
          state_n = DRAIN;
        end else begin
          we     = 1'b1;
          idx_n  = idx + CNT_W'(1);
          csum_n = csum ^ CSUM_W'(host.in_data);
        end
`else
        if (full) begin
          err_n   = 1'b1;
          state_n = host.in_last ? IDLE : DRAIN;
        end else begin
          we    = 1'b1;
          idx_n = idx + CNT_W'(1);
          if (host.in_last) begin
            fc_n    = idx + CNT_W'(1);
            state_n = ARM;
          end
        end
`endif
      end
      DRAIN: if (beat && host.in_last) state_n = IDLE;
      ARM: begin
        prog_loading = 1'b1;
        state_n      = HOLD;
      end
      HOLD: if (prog_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      frame_count <= '0;
      error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      frame_count <= fc_n;
      error       <= err_n;
`ifdef LOADER_CHECKSUM_EN
      csum        <= csum_n;
`endif
    end
  end

  prog_frame_store #(
    .FRAME_W  (FRAME_W),
    .N_FRAMES (N_FRAMES)
  ) u_store (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .clr    (clr),
    .widx   (wr_idx),
    .wdata  (host.in_data),
    .frames (data_frames_out)
  );

endmodule

// File: tb/tb_prog_frame_loader.sv
// tb/tb_prog_frame_loader.sv - directed scoreboard bench for prog_frame_loader
module tb_prog_frame_loader;
  import gpu_loader_pkg::*;

  localparam int NF = DEF_N_FRAMES;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  prog_done = 1'b0;
  logic                  prog_loading;
  logic                  busy;
  logic                  error;
  logic [DEF_CNT_W-1:0]  frame_count;
  logic [NF-1:0][15:0]   frames;

  int          tests = 0;
  int          fails = 0;
  int          pulses = 0;
  int          p0;
  int          nz;
  logic [15:0] d;
  logic [15:0] sb[$];

  prog_frame_loader_if #(.FRAME_W(16)) host ();

  prog_frame_loader dut (
    .clk             (clk),
    .reset           (reset),
    .host            (host),
    .prog_done       (prog_done),
    .prog_loading    (prog_loading),
    .data_frames_out (frames),
    .frame_count     (frame_count),
    .busy            (busy),
    .error           (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (prog_loading) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] data, input logic last, input int gap);
    host.in_valid = 1'b0;
    repeat (gap) tick();
    host.in_valid = 1'b1;
    host.in_data  = data;
    host.in_last  = last;
    for (int c = 0; c < 50 && !host.in_ready; c++) tick();
    chk("send_ready", {31'd0, host.in_ready}, 32'd1);
    tick();
    host.in_valid = 1'b0;
    host.in_last  = 1'b0;
  endtask

  task automatic count_nonzero(input int from);
    nz = 0;
    for (int i = from; i < NF; i++) if (frames[i] !== 16'h0) nz++;
  endtask

  initial begin
    host.in_valid = 1'b0;
    host.in_data  = '0;
    host.in_last  = 1'b0;
    repeat (2) tick();
    chk("rst_ready", {31'd0, host.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_loading", {31'd0, prog_loading}, 32'd0);
    chk("rst_count", {21'd0, frame_count}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b1;
    tick();

`ifdef LOADER_CHECKSUM_EN
    p0 = pulses;
    sb.push_back(16'h00FF); sb.push_back(16'h0F0F);
    send(16'h00FF, 1'b0, 0);
    send(16'h0F0F, 1'b0, 0);
    send(16'h0FF0, 1'b1, 0);
    chk("ck_strobe", {31'd0, prog_loading}, 32'd1);
    chk("ck_count", {21'd0, frame_count}, 32'd2);
    chk("ck_f0", {16'd0, frames[0]}, {16'd0, sb.pop_front()});
    chk("ck_f1", {16'd0, frames[1]}, {16'd0, sb.pop_front()});
    chk("ck_f2", {16'd0, frames[2]}, 32'd0);
    tick();
    prog_done = 1'b1; tick(); prog_done = 1'b0;
    p0 = pulses;
    send(16'h00FF, 1'b0, 0);
    send(16'h0F0F, 1'b0, 0);
    send(16'h0000, 1'b1, 0);
    chk("ck_bad_error", {31'd0, error}, 32'd1);
    chk("ck_bad_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("ck_bad_nopulse", pulses - p0, 32'd0);
`else
    // Four-word load, continuous valid
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      d = 16'((i + 1) * 16'h1111);
      sb.push_back(d);
      send(d, i == 3, 0);
    end
    chk("arm_strobe", {31'd0, prog_loading}, 32'd1);
    chk("arm_count", {21'd0, frame_count}, 32'd4);
    tick();
    chk("strobe_one_cycle", {31'd0, prog_loading}, 32'd0);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) chk("load4_frame", {16'd0, frames[i]}, {16'd0, sb.pop_front()});
    count_nonzero(4);
    chk("load4_upper_zero", nz, 32'd0);

    // Words offered during HOLD are refused and the image stays frozen
    host.in_valid = 1'b1; host.in_data = 16'hDEAD; host.in_last = 1'b1;
    repeat (3) begin
      tick();
      chk("hold_ready", {31'd0, host.in_ready}, 32'd0);
    end
    host.in_valid = 1'b0; host.in_last = 1'b0;
    chk("hold_frozen", {16'd0, frames[0]}, 32'h1111);
    chk("load4_one_pulse", pulses - p0, 32'd1);
    prog_done = 1'b1; tick(); prog_done = 1'b0;
    chk("release_busy", {31'd0, busy}, 32'd0);
    chk("release_ready", {31'd0, host.in_ready}, 32'd1);
    chk("persist_image", {16'd0, frames[3]}, 32'h4444);

    // Single-word load clears the old image
    sb.push_back(16'hBEEF);
    send(16'hBEEF, 1'b1, 0);
    chk("one_strobe", {31'd0, prog_loading}, 32'd1);
    chk("one_count", {21'd0, frame_count}, 32'd1);
    chk("one_f0", {16'd0, frames[0]}, {16'd0, sb.pop_front()});
    chk("one_f1", {16'd0, frames[1]}, 32'd0);
    tick();
    prog_done = 1'b1; tick(); prog_done = 1'b0;

    // Overflow: 1026 beats, last on the final one
    p0 = pulses;
    for (int i = 0; i < NF; i++) send(16'(i + 1), 1'b0, 0);
    chk("ovf_err_before", {31'd0, error}, 32'd0);
    send(16'hAAAA, 1'b0, 0);
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_drain_busy", {31'd0, busy}, 32'd1);
    send(16'hBBBB, 1'b1, 0);
    chk("ovf_idle", {31'd0, busy}, 32'd0);
    chk("ovf_sticky", {31'd0, error}, 32'd1);
    chk("ovf_count_kept", {21'd0, frame_count}, 32'd1);
    chk("ovf_partial", {16'd0, frames[NF-1]}, 32'd1024);
    chk("ovf_nopulse", pulses - p0, 32'd0);

    // Ten words with random valid gaps
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      sb.push_back(d);
      send(d, i == 9, $urandom_range(0, 3));
      if (i == 0) chk("err_cleared", {31'd0, error}, 32'd0);
    end
    repeat (3) tick();
    chk("gap_one_pulse", pulses - p0, 32'd1);
    chk("gap_count", {21'd0, frame_count}, 32'd10);
    for (int i = 0; i < 10; i++) chk("gap_frame", {16'd0, frames[i]}, {16'd0, sb.pop_front()});
    chk("gap_f10", {16'd0, frames[10]}, 32'd0);
    prog_done = 1'b1; tick(); prog_done = 1'b0;

    // Reset during a load discards everything
    for (int i = 0; i < 3; i++) send(16'h5A00 + 16'(i), 1'b0, 0);
    reset = 1'b0; tick(); reset = 1'b1;
    count_nonzero(0);
    chk("mid_rst_frames", nz, 32'd0);
    chk("mid_rst_count", {21'd0, frame_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, host.in_ready}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
